regfile_mp: RTL and testbench



---
 rtl/regfile_mp.sv | 117 +++++++++++
 tb/tb_regfile_mp.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module      : regfile_mp
// Description : Parametrised multi-port register file with a pending-write
//               scoreboard. NUM_RD combinational read ports, two write-back
//               ports (wr1 beats wr0 on an address collision), and one busy
//               bit per entry.
//               A busy bit is set by an issue and cleared by a write or a
//               flush. An issue wins over a same-cycle write to the same entry.
//               When ZERO_REG is nonzero, entry 0 reads as zero and is
//               never busy.
// Option      : define REGFILE_BYPASS_EN to forward same-cycle write data
//               (and a cleared busy bit) onto matching read ports.
// Ports       : clk, rst            clock, synchronous active-high reset
//               i_rd_addr/o_rd_data read address/data, port k at slice k
//               o_rd_busy           busy bit seen by each read port
//               i_wr0_*             write port 0 (low priority)
//               i_wr1_*             write port 1 (high priority)
//               i_iss_en/i_iss_addr mark an entry as having a pending producer
//               i_flush             clear every busy bit
//               o_any_busy          OR of all registered busy bits
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] i_rd_addr,
  output logic [NUM_RD*DATA_W-1:0] o_rd_data,
  output logic [NUM_RD-1:0]        o_rd_busy,
  input  logic                     i_wr0_en,
  input  logic [ADDR_W-1:0]        i_wr0_addr,
  input  logic [DATA_W-1:0]        i_wr0_data,
  input  logic                     i_wr1_en,
  input  logic [ADDR_W-1:0]        i_wr1_addr,
  input  logic [DATA_W-1:0]        i_wr1_data,
  input  logic                     i_iss_en,
  input  logic [ADDR_W-1:0]        i_iss_addr,
  input  logic                     i_flush,
  output logic                     o_any_busy
);

  localparam int c_DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0]  r_mem [c_DEPTH];
  logic [c_DEPTH-1:0] r_busy;
  logic [c_DEPTH-1:0] w_busy_nxt;
  logic               w_wr0_ok;
  logic               w_wr1_ok;

  // Writes to the hardwired zero entry are discarded.
  assign w_wr0_ok = i_wr0_en && !((ZERO_REG != 0) && (i_wr0_addr == '0));
  assign w_wr1_ok = i_wr1_en && !((ZERO_REG != 0) && (i_wr1_addr == '0));

  // Scoreboard next state. Later assignments take precedence: an issue
  // overrides a write-back clear, and a flush overrides everything.
  always_comb begin
    w_busy_nxt = r_busy;
    if (i_wr0_en) w_busy_nxt[i_wr0_addr] = 1'b0;
    if (i_wr1_en) w_busy_nxt[i_wr1_addr] = 1'b0;
    if (i_iss_en) w_busy_nxt[i_iss_addr] = 1'b1;
    if (i_flush)  w_busy_nxt = '0;
    if (ZERO_REG != 0) w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int a = 0; a < c_DEPTH; a++) begin
        r_mem[a] <= '0;
      end
      r_busy <= '0;
    end else begin
      // wr1 is assigned last, so it wins when both ports hit one entry.
      if (w_wr0_ok) r_mem[i_wr0_addr] <= i_wr0_data;
      if (w_wr1_ok) r_mem[i_wr1_addr] <= i_wr1_data;
      r_busy <= w_busy_nxt;
    end
  end

  assign o_any_busy = |r_busy;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic              w_busy;

    assign w_addr = i_rd_addr[k*ADDR_W +: ADDR_W];

    always_comb begin
      w_data = r_mem[w_addr];
      w_busy = r_busy[w_addr];
`ifdef REGFILE_BYPASS_EN
      if (i_wr1_en && (i_wr1_addr == w_addr)) begin
        w_data = i_wr1_data;
        w_busy = 1'b0;
      end else if (i_wr0_en && (i_wr0_addr == w_addr)) begin
        w_data = i_wr0_data;
        w_busy = 1'b0;
      end
`endif
      // The zero entry masks any forwarded value as well.
      if ((ZERO_REG != 0) && (w_addr == '0)) begin
        w_data = '0;
        w_busy = 1'b0;
      end
    end

    assign o_rd_data[k*DATA_W +: DATA_W] = w_data;
    assign o_rd_busy[k]                  = w_busy;
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_mp
// Description : Self-checking bench for regfile_mp. Two instances share the
//               stimulus, one with ZERO_REG=1 and one with ZERO_REG=0. A
//               behavioural array model predicts every read port and
//               any_busy each cycle. Directed steps pin literal values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_mp;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int D  = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [NR*AW-1:0] rd_addr;
  logic             wr0_en, wr1_en, iss_en, flush;
  logic [AW-1:0]    wr0_addr, wr1_addr, iss_addr;
  logic [DW-1:0]    wr0_data, wr1_data;

  logic [NR*DW-1:0] rd_data_z, rd_data_n;
  logic [NR-1:0]    rd_busy_z, rd_busy_n;
  logic             any_z, any_n;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1)) u_dut_z (
    .clk(clk), .rst(rst),
    .i_rd_addr(rd_addr), .o_rd_data(rd_data_z), .o_rd_busy(rd_busy_z),
    .i_wr0_en(wr0_en), .i_wr0_addr(wr0_addr), .i_wr0_data(wr0_data),
    .i_wr1_en(wr1_en), .i_wr1_addr(wr1_addr), .i_wr1_data(wr1_data),
    .i_iss_en(iss_en), .i_iss_addr(iss_addr), .i_flush(flush),
    .o_any_busy(any_z)
  );

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(0)) u_dut_n (
    .clk(clk), .rst(rst),
    .i_rd_addr(rd_addr), .o_rd_data(rd_data_n), .o_rd_busy(rd_busy_n),
    .i_wr0_en(wr0_en), .i_wr0_addr(wr0_addr), .i_wr0_data(wr0_data),
    .i_wr1_en(wr1_en), .i_wr1_addr(wr1_addr), .i_wr1_data(wr1_data),
    .i_iss_en(iss_en), .i_iss_addr(iss_addr), .i_flush(flush),
    .o_any_busy(any_n)
  );

  // Model state: index 0 mirrors the ZERO_REG=1 instance, index 1 the other.
  logic [DW-1:0] m_mem  [2][D];
  bit            m_busy [2][D];

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] exp_data(input int i, input logic [AW-1:0] a);
    if (i == 0 && a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (wr1_en && wr1_addr == a) return wr1_data;
    if (wr0_en && wr0_addr == a) return wr0_data;
`endif
    return m_mem[i][a];
  endfunction

  function automatic logic exp_busy(input int i, input logic [AW-1:0] a);
    if (i == 0 && a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if ((wr1_en && wr1_addr == a) || (wr0_en && wr0_addr == a)) return 1'b0;
`endif
    return m_busy[i][a];
  endfunction

  function automatic logic exp_any(input int i);
    for (int a = 0; a < D; a++) if (m_busy[i][a]) return 1'b1;
    return 1'b0;
  endfunction

  // Model update at each rising edge, applied in rule order.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        for (int a = 0; a < D; a++) begin
          m_mem[i][a]  = '0;
          m_busy[i][a] = 1'b0;
        end
      end else begin
        if (wr0_en && !(i == 0 && wr0_addr == 0)) m_mem[i][wr0_addr] = wr0_data;
        if (wr1_en && !(i == 0 && wr1_addr == 0)) m_mem[i][wr1_addr] = wr1_data;
        if (flush) begin
          for (int a = 0; a < D; a++) m_busy[i][a] = 1'b0;
        end else begin
          if (wr0_en) m_busy[i][wr0_addr] = 1'b0;
          if (wr1_en) m_busy[i][wr1_addr] = 1'b0;
          if (iss_en && !(i == 0 && iss_addr == 0)) m_busy[i][iss_addr] = 1'b1;
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < NR; k++) begin
        chk($sformatf("z port%0d data", k), rd_data_z[k*DW +: DW], exp_data(0, rd_addr[k*AW +: AW]));
        chk($sformatf("z port%0d busy", k), DW'(rd_busy_z[k]), DW'(exp_busy(0, rd_addr[k*AW +: AW])));
        chk($sformatf("n port%0d data", k), rd_data_n[k*DW +: DW], exp_data(1, rd_addr[k*AW +: AW]));
        chk($sformatf("n port%0d busy", k), DW'(rd_busy_n[k]), DW'(exp_busy(1, rd_addr[k*AW +: AW])));
      end
      chk("z any_busy", DW'(any_z), DW'(exp_any(0)));
      chk("n any_busy", DW'(any_n), DW'(exp_any(1)));
    end
  end

  task automatic idle();
    wr0_en = 1'b0; wr1_en = 1'b0; iss_en = 1'b0; flush = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic set_rd(input int k, input logic [AW-1:0] a);
    rd_addr[k*AW +: AW] = a;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 1) == 1) return AW'($urandom_range(0, 3));
    return AW'($urandom_range(0, D-1));
  endfunction

  initial begin
    rst = 1'b1;
    idle();
    rd_addr = '0;
    wr0_addr = '0; wr1_addr = '0; iss_addr = '0;
    wr0_data = '0; wr1_data = '0;
    tick();
    tick();
    rst = 1'b0;
    chk_en = 1'b1;

    // Reset state over every address, including the top entry.
    for (int a = 0; a < D; a++) begin
      set_rd(0, AW'(a));
      set_rd(1, AW'(D - 1 - a));
      settle();
      chk("reset data z", rd_data_z[0 +: DW], 32'h0);
      chk("reset data n", rd_data_n[DW +: DW], 32'h0);
      chk("reset any", DW'(any_z), 32'h0);
    end

    // Both ports hit entry 7: wr1 wins.
    wr0_en = 1'b1; wr0_addr = 5'd7; wr0_data = 32'hAAAA_AAAA;
    wr1_en = 1'b1; wr1_addr = 5'd7; wr1_data = 32'h5555_5555;
    tick();
    idle();
    set_rd(0, 5'd7);
    settle();
    chk("collide wr1 wins", rd_data_z[0 +: DW], 32'h5555_5555);

    // Entry 0 write: dropped only when hardwired.
    wr0_en = 1'b1; wr0_addr = 5'd0; wr0_data = 32'hDEAD_BEEF;
    tick();
    idle();
    set_rd(0, 5'd0);
    settle();
    chk("zero reg z", rd_data_z[0 +: DW], 32'h0);
    chk("zero reg n", rd_data_n[0 +: DW], 32'hDEAD_BEEF);

    // Issue, then write-back clears, then issue beats write.
    iss_en = 1'b1; iss_addr = 5'd5;
    tick();
    idle();
    set_rd(0, 5'd5);
    settle();
    chk("issue busy", DW'(rd_busy_z[0]), 32'h1);
    chk("issue any", DW'(any_z), 32'h1);
    wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 32'h1234;
    tick();
    idle();
    settle();
    chk("wb busy clr", DW'(rd_busy_z[0]), 32'h0);
    chk("wb data", rd_data_z[0 +: DW], 32'h1234);
    iss_en = 1'b1; iss_addr = 5'd5;
    wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 32'h5678;
    tick();
    idle();
    settle();
    chk("issue beats wb", DW'(rd_busy_z[0]), 32'h1);

    // Flush clears all and ignores the same-cycle issue.
    iss_en = 1'b1; iss_addr = 5'd3;
    tick();
    iss_addr = 5'd9;
    tick();
    flush = 1'b1; iss_addr = 5'd4;
    tick();
    idle();
    settle();
    chk("flush any z", DW'(any_z), 32'h0);
    chk("flush any n", DW'(any_n), 32'h0);

    // Same-cycle write-back on a busy entry seen through read port 1.
    wr0_en = 1'b1; wr0_addr = 5'd12; wr0_data = 32'h1111;
    tick();
    idle();
    iss_en = 1'b1; iss_addr = 5'd12;
    tick();
    idle();
    wr1_en = 1'b1; wr1_addr = 5'd12; wr1_data = 32'hCAFE;
    set_rd(1, 5'd12);
    settle();
`ifdef REGFILE_BYPASS_EN
    chk("bypass data", rd_data_z[DW +: DW], 32'hCAFE);
    chk("bypass busy", DW'(rd_busy_z[1]), 32'h0);
`else
    chk("no-bypass old data", rd_data_z[DW +: DW], 32'h1111);
    chk("no-bypass busy", DW'(rd_busy_z[1]), 32'h1);
`endif
    tick();
    idle();
    settle();
    chk("after wb data", rd_data_z[DW +: DW], 32'hCAFE);
    chk("after wb busy", DW'(rd_busy_z[1]), 32'h0);

    // Randomized traffic, checked every cycle by the compare process.
    repeat (3000) begin
      tick();
      rst      = ($urandom_range(0, 199) == 0);
      flush    = ($urandom_range(0, 15) == 0);
      iss_en   = ($urandom_range(0, 2) == 0);
      iss_addr = rand_addr();
      wr0_en   = ($urandom_range(0, 1) == 1);
      wr0_addr = rand_addr();
      wr0_data = $urandom;
      wr1_en   = ($urandom_range(0, 1) == 1);
      wr1_addr = rand_addr();
      wr1_data = $urandom;
      set_rd(0, rand_addr());
      set_rd(1, rand_addr());
    end

    rst = 1'b0;
    idle();
    settle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
